// File: rtl/tone_gen_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tone_gen_if -- note-code stage <-> tone generator bus         rev 1.0
// ---------------------------------------------------------------------------
interface tone_gen_if;
  logic [10:0] TO;
  logic        EN;
  logic        SPKS;
  logic        ACTIVE;

  modport master (output TO, output EN, input  SPKS, input  ACTIVE);
  modport slave  (input  TO, input  EN, output SPKS, output ACTIVE);
endinterface
`default_nettype wire

// File: rtl/tone_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tone_gen -- preset-counter square-wave speaker generator      rev 1.0
// Optional tick prescaler enabled by defining TONE_GEN_PRESCALE_EN.
// ---------------------------------------------------------------------------
module tone_gen #(
  parameter int PRESCALE = 4
) (
  input  logic      CLK,
  input  logic      RST_N,
  tone_gen_if.slave bus
);

  localparam logic [10:0] c_REST = 11'h7FF;

  logic w_tick;

`ifdef TONE_GEN_PRESCALE_EN
  localparam logic [7:0] c_PRE_LAST = 8'(PRESCALE - 1);

  logic [7:0] r_pre;

  // Free-running: independent of EN so tick phase is set only by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pre <= 8'd0;
    end else if (r_pre == c_PRE_LAST) begin
      r_pre <= 8'd0;
    end else begin
      r_pre <= r_pre + 8'd1;
    end
  end

  assign w_tick = (r_pre == c_PRE_LAST);
`else
  logic [7:0] w_unused_prescale;
  assign w_unused_prescale = 8'(PRESCALE);
  assign w_tick            = 1'b1;
`endif

  logic [10:0] r_cnt;
  logic [10:0] w_cnt_nxt;
  logic        r_spks;
  logic        w_spks_nxt;
  logic        r_active;
  logic        w_active_nxt;
  logic        w_reload;
  logic        w_rest;

  assign w_rest   = (bus.TO == c_REST);
  assign w_reload = w_tick && (r_cnt == c_REST);

  // Reload wins over increment, so the counter never wraps past 11'h7FF.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_spks_nxt   = r_spks;
    w_active_nxt = r_active;
    if (!bus.EN) begin
      w_cnt_nxt    = c_REST;
      w_spks_nxt   = 1'b0;
      w_active_nxt = 1'b0;
    end else if (w_reload) begin
      w_cnt_nxt    = bus.TO;
      w_spks_nxt   = w_rest ? 1'b0 : ~r_spks;
      w_active_nxt = ~w_rest;
    end else if (w_tick) begin
      w_cnt_nxt    = r_cnt + 11'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt    <= c_REST;
      r_spks   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_spks   <= w_spks_nxt;
      r_active <= w_active_nxt;
    end
  end

  assign bus.SPKS   = r_spks;
  assign bus.ACTIVE = r_active;

endmodule
`default_nettype wire

// File: tb/tb_tone_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tone_gen -- scoreboard bench: expected half-periods queued per tone.
// ---------------------------------------------------------------------------
module tb_tone_gen;

`ifdef TONE_GEN_PRESCALE_EN
  localparam int c_TICK = 4;
`else
  localparam int c_TICK = 1;
`endif

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  tone_gen_if bus ();

  tone_gen #(.PRESCALE(4)) u_dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int   n_checks  = 0;
  int   n_errors  = 0;
  int   exp_q[$];
  int   cyc       = 0;
  int   last_edge = 0;
  bit   have_edge = 1'b0;
  logic prev_spks = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Monitor: the first SPKS edge after queueing is a reference, later edges pop.
  always @(negedge CLK) begin
    cyc++;
    if (exp_q.size() == 0) begin
      have_edge = 1'b0;
    end else if (bus.SPKS !== prev_spks) begin
      if (have_edge) check("half_period", cyc - last_edge, exp_q.pop_front());
      have_edge = 1'b1;
      last_edge = cyc;
    end
    prev_spks = bus.SPKS;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic expect_halves(input int n, input int hp);
    have_edge = 1'b0;
    for (int i = 0; i < n; i++) exp_q.push_back(hp);
  endtask

  task automatic wait_spks(input logic lvl, input int budget, output int lat);
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (bus.SPKS !== lvl && lat < budget);
  endtask

  task automatic check_first(input string tag, input int lat);
`ifdef TONE_GEN_PRESCALE_EN
    check(tag, 32'(lat >= 1 && lat <= c_TICK), 1);
`else
    check(tag, lat, 1);
`endif
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic silence();
    bus.EN = 1'b0;
    cycles(2);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.TO = 11'h7FF;
    bus.EN = 1'b0;
    cycles(3);
    check("rst_spks",   32'(bus.SPKS),   0);
    check("rst_active", 32'(bus.ACTIVE), 0);

    // Shortest tone straight out of reset
    RST_N  = 1'b1;
    bus.EN = 1'b1;
    bus.TO = 11'h7FE;
    wait_spks(1'b1, 8 * c_TICK, lat);
    check_first("first_rise", lat);
    check("tone_active", 32'(bus.ACTIVE), 1);
    expect_halves(6, 2 * c_TICK);
    wait_drain("drain_7fe", 20 * c_TICK + 20);

    // Rest preset keeps the speaker silent
    silence();
    bus.TO = 11'h7FF;
    bus.EN = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      check("rest_spks",   32'(bus.SPKS),   0);
      check("rest_active", 32'(bus.ACTIVE), 0);
    end

    // Long tone, three full periods
    silence();
    expect_halves(6, 1275 * c_TICK);
    bus.TO = 11'h305;
    bus.EN = 1'b1;
    wait_drain("drain_305", 8 * 1275 * c_TICK);
    check("tone_305_active", 32'(bus.ACTIVE), 1);

    // Preset change mid half-period applies only at the next reload
    silence();
    expect_halves(1, 16 * c_TICK);
    exp_q.push_back(2 * c_TICK);
    exp_q.push_back(2 * c_TICK);
    exp_q.push_back(2 * c_TICK);
    bus.TO = 11'h7F0;
    bus.EN = 1'b1;
    wait_spks(1'b1, 4 * c_TICK, lat);
    check_first("rise_7f0", lat);
    cycles(4 * c_TICK);
    bus.TO = 11'h7FE;
    wait_drain("drain_switch", 40 * c_TICK + 10);

    // One-cycle EN drop mid-tone
    silence();
    bus.TO = 11'h7F0;
    bus.EN = 1'b1;
    wait_spks(1'b1, 4 * c_TICK, lat);
    check_first("rise_pre_drop", lat);
    cycles(6);
    check("pre_drop_spks", 32'(bus.SPKS), 1);
    bus.EN = 1'b0;
    cycles(1);
    check("drop_spks",   32'(bus.SPKS),   0);
    check("drop_active", 32'(bus.ACTIVE), 0);
    bus.EN = 1'b1;
    wait_spks(1'b1, 4 * c_TICK, lat);
    check_first("restore_reload", lat);
    check("restore_active", 32'(bus.ACTIVE), 1);
    expect_halves(1, 16 * c_TICK);
    wait_drain("drain_restore", 40 * c_TICK + 10);

    // Asynchronous reset between clock edges discards the phase
    silence();
    bus.TO = 11'h7F0;
    bus.EN = 1'b1;
    wait_spks(1'b1, 4 * c_TICK, lat);
    check_first("rise_pre_rst", lat);
    cycles(5);
    check("pre_rst_spks",   32'(bus.SPKS),   1);
    check("pre_rst_active", 32'(bus.ACTIVE), 1);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_spks",   32'(bus.SPKS),   0);
    check("async_rst_active", 32'(bus.ACTIVE), 0);
    cycles(2);
    expect_halves(2, 16 * c_TICK);
    RST_N = 1'b1;
    wait_spks(1'b1, 8 * c_TICK, lat);
`ifdef TONE_GEN_PRESCALE_EN
    check("post_rst_reload", lat, c_TICK);
`else
    check("post_rst_reload", lat, 1);
`endif
    wait_drain("drain_post_rst", 60 * c_TICK + 10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
